// File: rtl/sd_spi_cmd_seq.sv
// SD card SPI-mode command sequencer.
// Sends one framed SD command over a byte-wide SPI master, polls for the
// R1 response, and optionally streams one 512-byte read data block.
// Only one byte is ever in flight: launch, then wait for its received byte.
module sd_spi_cmd_seq #(
  parameter int RESP_POLL  = 8,
  parameter int TOKEN_POLL = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        rd_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic [1:0]  err,
  output logic        dat_valid,
  output logic [7:0]  dat_byte,
  output logic        cs_n,
  output logic [7:0]  spi_tx_byte,
  output logic        spi_tx_dv,
  input  logic        spi_tx_ready,
  input  logic        spi_rx_dv,
  input  logic [7:0]  spi_rx_byte
);

  localparam int DATA_BYTES = 512;
  localparam int CNT_MAX = (TOKEN_POLL > DATA_BYTES) ?
                           ((TOKEN_POLL > RESP_POLL) ? TOKEN_POLL : RESP_POLL) :
                           ((DATA_BYTES > RESP_POLL) ? DATA_BYTES : RESP_POLL);
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PRE   = 4'd1;
  localparam logic [3:0] S_CMD   = 4'd2;
  localparam logic [3:0] S_RESP  = 4'd3;
  localparam logic [3:0] S_TOKEN = 4'd4;
  localparam logic [3:0] S_DATA  = 4'd5;
  localparam logic [3:0] S_CRC   = 4'd6;
  localparam logic [3:0] S_POST  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wait_rx;
  logic          r_tx_dv;
  logic [7:0]    r_tx_byte;
  logic [7:0]    r_r1;
  logic [1:0]    r_err;
  logic [5:0]    r_idx;
  logic [31:0]   r_arg;
  logic [6:0]    r_crc;
  logic          r_rd;

  logic          w_busy;
  logic          w_launch;
  logic          w_rx_take;
  logic [7:0]    w_tx_byte;

  assign w_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_launch  = w_busy && !r_wait_rx && spi_tx_ready;
  assign w_rx_take = r_wait_rx && spi_rx_dv;

  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign cs_n        = !((r_state == S_PRE) || (r_state == S_CMD) || (r_state == S_RESP) ||
                         (r_state == S_TOKEN) || (r_state == S_DATA) || (r_state == S_CRC));
  assign dat_valid   = (r_state == S_DATA) && w_rx_take;
  assign dat_byte    = spi_rx_byte;
  assign spi_tx_dv   = r_tx_dv;
  assign spi_tx_byte = r_tx_byte;
  assign r1          = r_r1;
  assign err         = r_err;

  // Byte to launch next: command frame bytes in CMD, 0xFF filler everywhere else.
  always_comb begin
    w_tx_byte = 8'hFF;
    if (r_state == S_CMD) begin
      case (r_cnt[2:0])
        3'd0:    w_tx_byte = {2'b01, r_idx};
        3'd1:    w_tx_byte = r_arg[31:24];
        3'd2:    w_tx_byte = r_arg[23:16];
        3'd3:    w_tx_byte = r_arg[15:8];
        3'd4:    w_tx_byte = r_arg[7:0];
        3'd5:    w_tx_byte = {r_crc, 1'b1};
        default: w_tx_byte = 8'hFF;
      endcase
    end
  end

  // Transaction FSM: byte launch handshake plus per-state handling of each received byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wait_rx <= 1'b0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'hFF;
      r_r1      <= 8'hFF;
      r_err     <= 2'b00;
      r_idx     <= '0;
      r_arg     <= '0;
      r_crc     <= '0;
      r_rd      <= 1'b0;
    end else begin
      r_tx_dv <= 1'b0;
      if (w_launch) begin
        r_tx_dv   <= 1'b1;
        r_tx_byte <= w_tx_byte;
        r_wait_rx <= 1'b1;
      end
      if (r_state == S_IDLE) begin
        if (start) begin
          r_idx   <= cmd_idx;
          r_arg   <= cmd_arg;
          r_crc   <= cmd_crc;
          r_rd    <= rd_data;
          r_r1    <= 8'hFF;
          r_err   <= 2'b00;
          r_cnt   <= '0;
          r_state <= S_PRE;
        end
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end else if (w_rx_take) begin
        r_wait_rx <= 1'b0;
        case (r_state)
          S_PRE: begin
            r_cnt   <= '0;
            r_state <= S_CMD;
          end
          S_CMD: begin
            if (r_cnt == CW'(5)) begin
              r_cnt   <= '0;
              r_state <= S_RESP;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_RESP: begin
            if (!spi_rx_byte[7]) begin
              r_r1    <= spi_rx_byte;
              r_cnt   <= '0;
              r_state <= (r_rd && (spi_rx_byte[7:1] == 7'd0)) ? S_TOKEN : S_POST;
            end else if (r_cnt == CW'(RESP_POLL - 1)) begin
              r_err   <= 2'b01;
              r_cnt   <= '0;
              r_state <= S_POST;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_TOKEN: begin
            if (spi_rx_byte == 8'hFE) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
            end else if (spi_rx_byte[7:4] == 4'h0) begin
              r_err   <= 2'b11;
              r_cnt   <= '0;
              r_state <= S_POST;
            end else if (r_cnt == CW'(TOKEN_POLL - 1)) begin
              r_err   <= 2'b10;
              r_cnt   <= '0;
              r_state <= S_POST;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DATA: begin
            if (r_cnt == CW'(DATA_BYTES - 1)) begin
              r_cnt   <= '0;
              r_state <= S_CRC;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_CRC: begin
            if (r_cnt == CW'(1)) begin
              r_cnt   <= '0;
              r_state <= S_POST;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_POST:  r_state <= S_DONE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_seq.sv
// Testbench for sd_spi_cmd_seq: SPI byte-master model with random latency,
// a scripted card reply stream, and a transaction-level expectation model.
module tb_sd_spi_cmd_seq;

  localparam int RP = 8;
  localparam int TP = 16;
  localparam int BUDGET = 8000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        rd_data = 1'b0;
  logic        busy, done, dat_valid, cs_n, spi_tx_dv;
  logic [7:0]  r1, dat_byte, spi_tx_byte;
  logic [1:0]  err;
  logic        spi_tx_ready = 1'b1;
  logic        spi_rx_dv = 1'b0;
  logic [7:0]  spi_rx_byte = 8'h00;

  sd_spi_cmd_seq #(.RESP_POLL(RP), .TOKEN_POLL(TP)) dut (
    .clk(clk), .resetn(resetn), .start(start), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
    .cmd_crc(cmd_crc), .rd_data(rd_data), .busy(busy), .done(done), .r1(r1), .err(err),
    .dat_valid(dat_valid), .dat_byte(dat_byte), .cs_n(cs_n), .spi_tx_byte(spi_tx_byte),
    .spi_tx_dv(spi_tx_dv), .spi_tx_ready(spi_tx_ready), .spi_rx_dv(spi_rx_dv),
    .spi_rx_byte(spi_rx_byte)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // card reply script (index = transfer number), written by the test sequence only
  logic [7:0] card_q[$];
  int card_gen = 0;
  int inj_req = 0;

  // written by the SPI model only
  logic [7:0] tx_log[$];
  logic       cs_log[$];
  int  viol_m = 0;
  int  m_gen = 0, m_k = 0, m_lat = 0, inj_ack = 0;
  bit  m_pend = 0, m_prev_dv = 0;

  // written by the output monitor only
  logic [7:0] dat_log[$];
  int done_cnt = 0;
  int viol_d = 0;

  // expectation
  logic [7:0] exp_tx[$];
  logic [7:0] exp_dat[$];
  logic [7:0] exp_r1;
  logic [1:0] exp_err;

  // SPI byte master model: drives inputs 1 time unit after the rising edge
  always @(posedge clk) begin
    #1;
    if (m_gen != card_gen) begin
      m_gen = card_gen;
      m_k = 0;
    end
    if (spi_tx_dv && (!spi_tx_ready || m_pend || m_prev_dv)) viol_m++;
    m_prev_dv = spi_tx_dv;
    if (spi_rx_dv) begin
      spi_rx_dv = 1'b0;
      spi_tx_ready = 1'b1;
    end else if (m_pend) begin
      if (m_lat == 0) begin
        spi_rx_byte = (m_k < card_q.size()) ? card_q[m_k] : 8'hFF;
        m_k++;
        spi_rx_dv = 1'b1;
        m_pend = 0;
      end else begin
        m_lat--;
      end
    end else if (spi_tx_dv) begin
      tx_log.push_back(spi_tx_byte);
      cs_log.push_back(cs_n);
      m_pend = 1;
      m_lat = $urandom_range(0, 3);
      spi_tx_ready = 1'b0;
    end else if (inj_req != inj_ack) begin
      inj_ack = inj_req;
      spi_rx_byte = 8'h00;
      spi_rx_dv = 1'b1;
    end
  end

  // output monitor on the falling edge
  always @(negedge clk) begin
    if (dat_valid) dat_log.push_back(dat_byte);
    if (done) begin
      done_cnt++;
      if (busy) viol_d++;
    end
  end

  function automatic logic [7:0] card_at(int k);
    return (k < card_q.size()) ? card_q[k] : 8'hFF;
  endfunction

  task automatic new_script();
    card_q.delete();
    repeat (7) card_q.push_back(8'hFF);
    card_gen++;
  endtask

  // Expected transaction outcome derived from the card reply script
  task automatic compute_expected(input logic [5:0] idx, input logic [31:0] arg,
                                  input logic [6:0] crc, input logic rd);
    int k;
    bit got, found;
    logic [7:0] b;
    exp_tx.delete();
    exp_dat.delete();
    exp_r1 = 8'hFF;
    exp_err = 2'b00;
    exp_tx.push_back(8'hFF);
    exp_tx.push_back({2'b01, idx});
    exp_tx.push_back(arg[31:24]);
    exp_tx.push_back(arg[23:16]);
    exp_tx.push_back(arg[15:8]);
    exp_tx.push_back(arg[7:0]);
    exp_tx.push_back({crc, 1'b1});
    k = 7;
    got = 0;
    for (int p = 0; p < RP && !got; p++) begin
      b = card_at(k); k++;
      exp_tx.push_back(8'hFF);
      if (!b[7]) begin got = 1; exp_r1 = b; end
    end
    if (!got) exp_err = 2'b01;
    else if (rd && exp_r1[7:1] == 7'd0) begin
      found = 0;
      for (int p = 0; p < TP && !found && exp_err == 2'b00; p++) begin
        b = card_at(k); k++;
        exp_tx.push_back(8'hFF);
        if (b == 8'hFE) found = 1;
        else if (b[7:4] == 4'h0) exp_err = 2'b11;
      end
      if (!found && exp_err == 2'b00) exp_err = 2'b10;
      if (found) begin
        for (int i = 0; i < 512; i++) begin
          exp_tx.push_back(8'hFF);
          exp_dat.push_back(card_at(k)); k++;
        end
        repeat (2) exp_tx.push_back(8'hFF);
      end
    end
    exp_tx.push_back(8'hFF);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input logic rd, input bit rogue, input string nm);
    int n, tb0, db0, dc0, vm0, vd0, bad, first, ntx, ndat;
    compute_expected(idx, arg, crc, rd);
    @(negedge clk);
    tb0 = tx_log.size(); db0 = dat_log.size(); dc0 = done_cnt; vm0 = viol_m; vd0 = viol_d;
    cmd_idx = idx; cmd_arg = arg; cmd_crc = crc; rd_data = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_after_start got=%b exp=1", nm, busy); end
    if (rogue) begin
      repeat (15) @(negedge clk);
      cmd_idx = ~idx; cmd_arg = ~arg; cmd_crc = ~crc; rd_data = ~rd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done_cnt == dc0 && n < BUDGET) begin @(negedge clk); n++; end
    checks++;
    if (n >= BUDGET) begin failures++; $display("FAIL %s_timeout waited=%0d cycles exp=done", nm, n); end
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt - dc0 !== 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", nm, done_cnt - dc0); end
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin failures++; $display("FAIL %s_idle got busy=%b cs_n=%b exp busy=0 cs_n=1", nm, busy, cs_n); end
    checks++;
    if (r1 !== exp_r1) begin failures++; $display("FAIL %s_r1 got=%02h exp=%02h", nm, r1, exp_r1); end
    checks++;
    if (err !== exp_err) begin failures++; $display("FAIL %s_err got=%b exp=%b", nm, err, exp_err); end
    ntx = tx_log.size() - tb0;
    checks++;
    if (ntx != exp_tx.size()) begin failures++; $display("FAIL %s_tx_count got=%0d exp=%0d", nm, ntx, exp_tx.size()); end
    bad = 0; first = -1;
    for (int i = 0; i < ntx && i < exp_tx.size(); i++)
      if (tx_log[tb0+i] !== exp_tx[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s_tx_bytes first_bad=%0d got=%02h exp=%02h", nm, first, tx_log[tb0+first], exp_tx[first]); end
    bad = 0;
    for (int i = 0; i < ntx; i++)
      if (cs_log[tb0+i] !== ((i == ntx - 1) ? 1'b1 : 1'b0)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s_cs_n_at_launch bad_launches got=%0d exp=0", nm, bad); end
    ndat = dat_log.size() - db0;
    checks++;
    if (ndat != exp_dat.size()) begin failures++; $display("FAIL %s_dat_count got=%0d exp=%0d", nm, ndat, exp_dat.size()); end
    bad = 0; first = -1;
    for (int i = 0; i < ndat && i < exp_dat.size(); i++)
      if (dat_log[db0+i] !== exp_dat[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s_dat_bytes first_bad=%0d got=%02h exp=%02h", nm, first, dat_log[db0+first], exp_dat[first]); end
    checks++;
    if (viol_m != vm0 || viol_d != vd0) begin failures++; $display("FAIL %s_protocol got=%0d violations exp=0", nm, (viol_m - vm0) + (viol_d - vd0)); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || dat_valid !== 1'b0 || spi_tx_dv !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl got cs_n=%b busy=%b done=%b dv=%b txdv=%b exp 1 0 0 0 0", cs_n, busy, done, dat_valid, spi_tx_dv);
    end
    checks++;
    if (r1 !== 8'hFF || err !== 2'b00 || spi_tx_byte !== 8'hFF) begin
      failures++; $display("FAIL reset_data got r1=%02h err=%b tx=%02h exp FF 00 FF", r1, err, spi_tx_byte);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1 || tx_log.size() != 0) begin
      failures++; $display("FAIL reset_release_idle got busy=%b cs_n=%b tx=%0d exp 0 1 0", busy, cs_n, tx_log.size());
    end
  endtask

  task automatic test_cmd0();
    int tb0;
    new_script();
    card_q.push_back(8'hFF); card_q.push_back(8'h01);
    @(negedge clk);
    tb0 = tx_log.size();
    run_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b0, "cmd0");
    checks++;
    if (tx_log.size() - tb0 != 10 || tx_log[tb0+1] !== 8'h40 || tx_log[tb0+6] !== 8'h95 || tx_log[tb0+9] !== 8'hFF) begin
      failures++; $display("FAIL cmd0_frame got n=%0d b1=%02h b6=%02h exp n=10 b1=40 b6=95", tx_log.size() - tb0, tx_log[tb0+1], tx_log[tb0+6]);
    end
  endtask

  task automatic test_cmd17_read();
    new_script();
    card_q.push_back(8'h00);
    repeat (3) card_q.push_back(8'hFF);
    card_q.push_back(8'hFE);
    for (int i = 0; i < 512; i++) card_q.push_back(8'(i % 256));
    card_q.push_back(8'h5A); card_q.push_back(8'hC3);
    run_cmd(6'd17, 32'h0000_1200, 7'h2B, 1'b1, 1'b1, "cmd17");
  endtask

  task automatic test_resp_timeout();
    new_script();
    run_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1'b0, "r1_timeout");
  endtask

  task automatic test_r1_error();
    new_script();
    card_q.push_back(8'hFF); card_q.push_back(8'h04); card_q.push_back(8'hFE);
    run_cmd(6'd17, 32'h1, 7'h11, 1'b1, 1'b0, "r1_err_no_token");
  endtask

  task automatic test_token_err();
    new_script();
    card_q.push_back(8'h00); card_q.push_back(8'hFF); card_q.push_back(8'h08);
    run_cmd(6'd17, 32'h2, 7'h22, 1'b1, 1'b0, "token_err");
  endtask

  task automatic test_token_timeout();
    new_script();
    card_q.push_back(8'h00);
    run_cmd(6'd17, 32'h3, 7'h33, 1'b1, 1'b0, "token_timeout");
  endtask

  task automatic test_spurious_rx();
    int tb0, db0, dc0;
    @(negedge clk);
    tb0 = tx_log.size(); db0 = dat_log.size(); dc0 = done_cnt;
    inj_req++;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || r1 !== exp_r1 || tx_log.size() != tb0 || dat_log.size() != db0 || done_cnt != dc0) begin
      failures++; $display("FAIL spurious_rx got busy=%b r1=%02h tx=%0d dat=%0d exp busy=0 r1=%02h no activity", busy, r1, tx_log.size() - tb0, dat_log.size() - db0, exp_r1);
    end
  endtask

  task automatic test_random();
    int lead, kind, tlead;
    logic [7:0] r1v;
    for (int it = 0; it < 6; it++) begin
      new_script();
      lead = $urandom_range(0, 9);
      repeat (lead) card_q.push_back(8'hFF);
      kind = $urandom_range(0, 2);
      r1v = (kind == 0) ? 8'h00 : (kind == 1) ? 8'h01 : {1'b0, 7'($urandom)};
      card_q.push_back(r1v);
      tlead = $urandom_range(0, 18);
      for (int i = 0; i < tlead; i++)
        card_q.push_back($urandom_range(0, 1) ? 8'hFF : 8'($urandom_range(16, 253)));
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        card_q.push_back(8'hFE);
        repeat (514) card_q.push_back(8'($urandom));
      end else if (kind == 1) begin
        card_q.push_back({4'h0, 4'($urandom)});
      end
      run_cmd(6'($urandom), $urandom, 7'($urandom), 1'($urandom), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    new_script();
    card_q.push_back(8'h01);
    run_cmd(6'd55, 32'h0, 7'h32, 1'b0, 1'b0, "b2b_a");
    new_script();
    card_q.push_back(8'hFF); card_q.push_back(8'h00);
    run_cmd(6'd41, 32'h4000_0000, 7'h3B, 1'b0, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid_data();
    int n, dc0;
    new_script();
    card_q.push_back(8'h00); card_q.push_back(8'hFE);
    repeat (514) card_q.push_back(8'($urandom));
    @(negedge clk);
    dc0 = done_cnt;
    cmd_idx = 6'd17; cmd_arg = 32'h10; cmd_crc = 7'h01; rd_data = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dat_log.size() < 100 && n < BUDGET) begin @(negedge clk); n++; end
    checks++;
    if (n >= BUDGET) begin failures++; $display("FAIL rst_mid_reach_data got=%0d bytes exp=100", dat_log.size()); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || spi_tx_dv !== 1'b0 || dat_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async got cs_n=%b busy=%b done=%b txdv=%b dv=%b exp 1 0 0 0 0", cs_n, busy, done, spi_tx_dv, dat_valid);
    end
    checks++;
    if (r1 !== 8'hFF || err !== 2'b00 || spi_tx_byte !== 8'hFF) begin
      failures++; $display("FAIL rst_mid_regs got r1=%02h err=%b tx=%02h exp FF 00 FF", r1, err, spi_tx_byte);
    end
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while ((m_pend || spi_rx_dv || !spi_tx_ready) && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != dc0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid_no_done got done=%0d busy=%b exp done=0 busy=0", done_cnt - dc0, busy);
    end
    new_script();
    card_q.push_back(8'hFF); card_q.push_back(8'h01);
    run_cmd(6'd0, 32'h0, 7'h4A, 1'b0, 1'b1, "rst_mid_cmd0");
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd17_read();
    test_resp_timeout();
    test_r1_error();
    test_token_err();
    test_token_timeout();
    test_spurious_rx();
    test_random();
    test_back_to_back();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
